// File: rtl/sdrd_deserializer_pkg.sv
// Shared types and helpers for the SDRD serial-read deserializer.
package sdrd_deserializer_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int FRAME_BITS = 8;

  // 1 when data plus parity bit has odd weight, i.e. the frame is good
  function automatic logic odd_par_ok(input logic [FRAME_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/sdrd_rx_fifo.sv
// Small DEPTH x W output FIFO; head is presented combinationally, 0 when empty.
module sdrd_rx_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  // pop on empty is ignored; a pop frees a slot for a same-cycle push when full
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_dout  = o_empty ? '0 : r_mem[r_rd];

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= nxt(r_wr);
      end
      if (w_pop) r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/sdrd_deserializer.sv
// Deserializes start/8-bit MSB-first/odd-parity frames sampled only in the
// serial read window, and buffers completed bytes for a ready/valid consumer.
module sdrd_deserializer
  import sdrd_deserializer_pkg::*;
#(
  parameter int GAP_MAX = 15,
  parameter int DEPTH   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SSER,
  input  logic       BA13,
  input  logic       BA12,
  input  logic       BR_W,
  input  logic       SD_EN,
  input  logic       SDRD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       overrun,
  output logic       abort,
  input  logic       err_clr,
  output logic       busy
);
  localparam int GW = $clog2(GAP_MAX + 1);
  localparam int CW = $clog2(FRAME_BITS + 1);

  state_e                r_state, w_next;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic [GW-1:0]         r_gap;
  logic                  r_perr, r_ovr, r_abort;
  logic                  w_win, w_timeout, w_last_bit;
  logic                  w_push, w_pop, w_full, w_empty, w_perr_set, w_ovr_set;

  assign w_win      = ~SSER & ~BA13 & BA12 & BR_W & SD_EN;
  assign w_last_bit = (r_cnt == CW'(FRAME_BITS - 1));
  assign w_timeout  = (r_state != IDLE) & ~w_win & (r_gap == GW'(GAP_MAX - 1));
  assign w_pop      = rx_ready & rx_valid;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state: advance on bit cycles, bail to IDLE on gap timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_win & ~SDRD) w_next = SHIFT;
      SHIFT:   if (w_timeout) w_next = IDLE;
               else if (w_win & w_last_bit) w_next = PARITY;
      PARITY:  if (w_timeout | w_win) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // outputs: busy, buffer push on the parity bit cycle, error set strobes
  always_comb begin
    busy       = (r_state != IDLE);
    w_push     = (r_state == PARITY) & w_win;
    w_perr_set = w_push & ~odd_par_ok(r_shift, SDRD);
    w_ovr_set  = w_push & w_full & ~w_pop;
  end

  // shift register, bit counter and gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else if (r_state == IDLE) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else if (w_win) begin
      r_gap <= '0;
      if (r_state == SHIFT) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], SDRD};
        r_cnt   <= r_cnt + 1'b1;
      end
    end else begin
      r_gap <= r_gap + 1'b1;
    end
  end

  // sticky error flags (a new error beats err_clr) and the abort pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_perr  <= w_perr_set | (r_perr & ~err_clr);
      r_ovr   <= w_ovr_set  | (r_ovr  & ~err_clr);
      r_abort <= w_timeout;
    end
  end

  assign parity_err = r_perr;
  assign overrun    = r_ovr;
  assign abort      = r_abort;
  assign rx_valid   = ~w_empty;

  sdrd_rx_fifo #(.DEPTH(DEPTH), .W(FRAME_BITS)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (r_shift),
    .i_pop   (w_pop),
    .o_dout  (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule
